// File: rtl/chan_mux_nxw.sv
// ---------------------------------------------------------------------------
// chan_mux_nxw
//
// Registered N-channel x W-bit channel selector with break-before-make
// switching. One of N_CH input buses is routed to a registered output.
// A channel change is requested over a valid/ready handshake. Before the new
// channel is connected, the output is blanked to IDLE_VAL so that no glitch
// or mixture of old and new channel data reaches the tester lines.
//
// Parameters
//   N_CH       number of input channels (2..256)
//   DATA_W     width of each channel bus in bits (>=1)
//   SEL_W      select width, derived from N_CH (do not override)
//   GUARD_CYC  number of cycles spent in the blanking state (>=1)
//   IDLE_VAL   value driven on mux_out_o during reset and blanking
//   RST_SEL    channel connected out of reset (< N_CH)
//
// Ports
//   clk_i         system clock, all logic on the rising edge
//   rst_i         asynchronous reset, active-high
//   in_data_i     packed channel buses, channel k at [k*DATA_W +: DATA_W]
//   sel_req_i     requested channel index
//   sel_valid_i   sel_req_i is valid; requester holds it until accepted
//   sel_ready_o   block can accept a request this cycle
//   sel_active_o  channel currently connected to mux_out_o
//   mux_out_o     registered selected channel data
//   switching_o   high while mux_out_o is blanked for a channel change
//   sel_err_o     one-cycle pulse after an out-of-range request is rejected
// ---------------------------------------------------------------------------
module chan_mux_nxw #(
  parameter int                 N_CH      = 8,
  parameter int                 DATA_W    = 1,
  parameter int                 SEL_W     = $clog2(N_CH),
  parameter int                 GUARD_CYC = 4,
  parameter logic [DATA_W-1:0]  IDLE_VAL  = '0,
  parameter int                 RST_SEL   = 0
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [N_CH*DATA_W-1:0]   in_data_i,
  input  logic [SEL_W-1:0]         sel_req_i,
  input  logic                     sel_valid_i,
  output logic                     sel_ready_o,
  output logic [SEL_W-1:0]         sel_active_o,
  output logic [DATA_W-1:0]        mux_out_o,
  output logic                     switching_o,
  output logic                     sel_err_o
);

  // Guard counter only needs to hold GUARD_CYC-1 down to zero.
  localparam int               CNT_W      = $clog2(GUARD_CYC + 1);
  localparam logic [CNT_W-1:0] GUARD_LOAD = CNT_W'(GUARD_CYC - 1);
  localparam logic [SEL_W-1:0] RST_SEL_V  = SEL_W'(RST_SEL);

  // One extra bit lets the range check work when N_CH is a power of two
  // and therefore not representable in SEL_W bits.
  localparam logic [SEL_W:0]   N_CH_EXT   = (SEL_W + 1)'(N_CH);

  typedef enum logic [0:0] {
    ACTIVE = 1'b0,
    BLANK  = 1'b1
  } state_t;

  state_t              state_q,     state_d;
  logic [SEL_W-1:0]    selActive_q, selActive_d;
  logic [SEL_W-1:0]    pendSel_q,   pendSel_d;
  logic [CNT_W-1:0]    guardCnt_q,  guardCnt_d;
  logic [DATA_W-1:0]   muxOut_q,    muxOut_d;
  logic                switching_q, switching_d;
  logic                selErr_q,    selErr_d;

  logic [DATA_W-1:0]   chanBus [N_CH];
  logic                accept;
  logic                reqInRange;

  // Unpack the flat input bus into one element per channel so the data path
  // is a plain array lookup indexed by the active channel.
  for (genvar k = 0; k < N_CH; k++) begin : gUnpack
    assign chanBus[k] = in_data_i[k*DATA_W +: DATA_W];
  end

  // A request is only taken while connected; during blanking the requester
  // keeps sel_valid_i high and is served on the first ACTIVE cycle.
  assign accept     = sel_valid_i & (state_q == ACTIVE);
  assign reqInRange = ({1'b0, sel_req_i} < N_CH_EXT);

  // Next-state and datapath decode. Every register defaults to holding its
  // value except mux_out, switching and sel_err, which are recomputed each
  // cycle. switching is registered alongside mux_out so it stays high for the
  // whole blanked window, including the cycle after the counter expires when
  // the new channel is connected but not yet sampled.
  always_comb begin
    state_d     = state_q;
    selActive_d = selActive_q;
    pendSel_d   = pendSel_q;
    guardCnt_d  = guardCnt_q;
    muxOut_d    = IDLE_VAL;
    switching_d = 1'b0;
    selErr_d    = 1'b0;

    case (state_q)
      ACTIVE: begin
        muxOut_d = chanBus[selActive_q];
        if (accept) begin
          if (!reqInRange) begin
            selErr_d = 1'b1;
          end else if (sel_req_i != selActive_q) begin
            state_d     = BLANK;
            pendSel_d   = sel_req_i;
            guardCnt_d  = GUARD_LOAD;
            muxOut_d    = IDLE_VAL;
            switching_d = 1'b1;
          end
        end
      end

      BLANK: begin
        switching_d = 1'b1;
        muxOut_d    = IDLE_VAL;
        if (guardCnt_q == '0) begin
          state_d     = ACTIVE;
          selActive_d = pendSel_q;
        end else begin
          guardCnt_d  = guardCnt_q - 1'b1;
        end
      end

      default: begin
        state_d = ACTIVE;
      end
    endcase
  end

  // State and output registers. Reset drops straight back to the initial
  // channel with the output idle, discarding any pending channel change.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ACTIVE;
      selActive_q <= RST_SEL_V;
      pendSel_q   <= RST_SEL_V;
      guardCnt_q  <= '0;
      muxOut_q    <= IDLE_VAL;
      switching_q <= 1'b0;
      selErr_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      selActive_q <= selActive_d;
      pendSel_q   <= pendSel_d;
      guardCnt_q  <= guardCnt_d;
      muxOut_q    <= muxOut_d;
      switching_q <= switching_d;
      selErr_q    <= selErr_d;
    end
  end

  assign sel_ready_o  = (state_q == ACTIVE);
  assign sel_active_o = selActive_q;
  assign mux_out_o    = muxOut_q;
  assign switching_o  = switching_q;
  assign sel_err_o    = selErr_q;

endmodule

// File: tb/tb_chan_mux_nxw.sv
// ---------------------------------------------------------------------------
// tb_chan_mux_nxw
//
// Directed bench for chan_mux_nxw with N_CH=6, DATA_W=4, GUARD_CYC=4 and a
// non-zero idle value. Each table row describes one clock cycle: the inputs
// driven during that cycle and the outputs expected during that same cycle
// (the result of the previous rising edge). The stimulus process drives a
// row and pushes its expectation; a separate monitor pops and compares on
// every falling edge.
// ---------------------------------------------------------------------------
module tb_chan_mux_nxw;

  localparam int          N_CH      = 6;
  localparam int          DATA_W    = 4;
  localparam int          SEL_W     = 3;
  localparam int          GUARD_CYC = 4;
  localparam logic [3:0]  IDLE      = 4'hE;

  // Channel k in nibble k: D0 gives ch0=1..ch5=6, D1 gives ch0=8..ch5=D.
  localparam logic [23:0] D0 = 24'h654321;
  localparam logic [23:0] D1 = 24'hDCBA98;

  logic                    clk;
  logic                    rst;
  logic [N_CH*DATA_W-1:0]  inData;
  logic [SEL_W-1:0]        selReq;
  logic                    selValid;
  logic                    selReady;
  logic [SEL_W-1:0]        selActive;
  logic [DATA_W-1:0]       muxOut;
  logic                    switching;
  logic                    selErr;

  typedef struct packed {
    logic        rst;
    logic [23:0] data;
    logic [2:0]  req;
    logic        vld;
  } stim_t;

  typedef struct packed {
    logic [15:0] row;
    logic        ready;
    logic [2:0]  active;
    logic [3:0]  mux;
    logic        sw;
    logic        err;
  } exp_t;

  stim_t stimTab[$];
  exp_t  expTab[$];
  exp_t  scoreQ[$];
  exp_t  monExp;

  int checkCount = 0;
  int passCount  = 0;

  chan_mux_nxw #(
    .N_CH      (N_CH),
    .DATA_W    (DATA_W),
    .GUARD_CYC (GUARD_CYC),
    .IDLE_VAL  (IDLE),
    .RST_SEL   (0)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .in_data_i    (inData),
    .sel_req_i    (selReq),
    .sel_valid_i  (selValid),
    .sel_ready_o  (selReady),
    .sel_active_o (selActive),
    .mux_out_o    (muxOut),
    .switching_o  (switching),
    .sel_err_o    (selErr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Append one cycle: inputs for the cycle, then the outputs expected in it.
  task automatic addRow(input logic r, input logic [23:0] d, input logic [2:0] q,
                        input logic v, input logic eRdy, input logic [2:0] eAct,
                        input logic [3:0] eMux, input logic eSw, input logic eErr);
    stim_t s;
    exp_t  e;
    s.rst  = r;
    s.data = d;
    s.req  = q;
    s.vld  = v;
    e.row    = 16'(expTab.size());
    e.ready  = eRdy;
    e.active = eAct;
    e.mux    = eMux;
    e.sw     = eSw;
    e.err    = eErr;
    stimTab.push_back(s);
    expTab.push_back(e);
  endtask

  // Drive one row just after the rising edge and hand its expectation to
  // the scoreboard.
  task automatic applyStimulus(input int idx);
    @(posedge clk);
    #1;
    rst      = stimTab[idx].rst;
    inData   = stimTab[idx].data;
    selReq   = stimTab[idx].req;
    selValid = stimTab[idx].vld;
    scoreQ.push_back(expTab[idx]);
  endtask

  task automatic checkOutput(input string name, input logic [15:0] row,
                             input logic [7:0] act, input logic [7:0] want);
    checkCount++;
    if (act === want) begin
      passCount++;
    end else begin
      $display("[TB] FAIL row %0d %s: got 0x%0h, expected 0x%0h", row, name, act, want);
    end
  endtask

  // Monitor: every falling edge with a pending expectation compares all
  // outputs against it.
  always @(negedge clk) begin
    if (scoreQ.size() != 0) begin
      monExp = scoreQ.pop_front();
      checkOutput("sel_ready",  monExp.row, 8'(selReady),  8'(monExp.ready));
      checkOutput("sel_active", monExp.row, 8'(selActive), 8'(monExp.active));
      checkOutput("mux_out",    monExp.row, 8'(muxOut),    8'(monExp.mux));
      checkOutput("switching",  monExp.row, 8'(switching), 8'(monExp.sw));
      checkOutput("sel_err",    monExp.row, 8'(selErr),    8'(monExp.err));
    end
  end

  initial begin
    rst      = 1'b1;
    inData   = D0;
    selReq   = '0;
    selValid = 1'b0;

    //      rst  data  req  vld | rdy act mux   sw  err
    // Reset held, then released; ch0 sampled on the first edge after release.
    addRow(1'b1, D0, 3'd0, 1'b0, 1'b1, 3'd0, IDLE, 1'b0, 1'b0);
    addRow(1'b1, D0, 3'd0, 1'b0, 1'b1, 3'd0, IDLE, 1'b0, 1'b0);
    addRow(1'b0, D0, 3'd0, 1'b0, 1'b1, 3'd0, IDLE, 1'b0, 1'b0);
    addRow(1'b0, D0, 3'd0, 1'b0, 1'b1, 3'd0, 4'h1, 1'b0, 1'b0);
    // Data change tracked with one cycle latency; out-of-range request 7.
    addRow(1'b0, D1, 3'd0, 1'b0, 1'b1, 3'd0, 4'h1, 1'b0, 1'b0);
    addRow(1'b0, D1, 3'd7, 1'b1, 1'b1, 3'd0, 4'h8, 1'b0, 1'b0);
    addRow(1'b0, D0, 3'd0, 1'b0, 1'b1, 3'd0, 4'h8, 1'b0, 1'b1);
    // Request for the already active channel: no blanking.
    addRow(1'b0, D0, 3'd0, 1'b1, 1'b1, 3'd0, 4'h1, 1'b0, 1'b0);
    addRow(1'b0, D0, 3'd0, 1'b0, 1'b1, 3'd0, 4'h1, 1'b0, 1'b0);
    // Switch to ch5: blanked for GUARD_CYC+1 cycles, then ch5 data.
    addRow(1'b0, D0, 3'd5, 1'b1, 1'b1, 3'd0, 4'h1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++)
      addRow(1'b0, D0, 3'd0, 1'b0, 1'b0, 3'd0, IDLE, 1'b1, 1'b0);
    addRow(1'b0, D0, 3'd0, 1'b0, 1'b1, 3'd5, IDLE, 1'b1, 1'b0);
    // Switch to ch2, with a ch3 request held throughout the blanking.
    addRow(1'b0, D0, 3'd2, 1'b1, 1'b1, 3'd5, 4'h6, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++)
      addRow(1'b0, D0, 3'd3, 1'b1, 1'b0, 3'd5, IDLE, 1'b1, 1'b0);
    addRow(1'b0, D0, 3'd3, 1'b1, 1'b1, 3'd2, IDLE, 1'b1, 1'b0);
    // Held ch3 request taken on the first ACTIVE cycle.
    for (int i = 0; i < 4; i++)
      addRow(1'b0, D0, 3'd0, 1'b0, 1'b0, 3'd2, IDLE, 1'b1, 1'b0);
    addRow(1'b0, D0, 3'd0, 1'b0, 1'b1, 3'd3, IDLE, 1'b1, 1'b0);
    addRow(1'b0, D1, 3'd0, 1'b0, 1'b1, 3'd3, 4'h4, 1'b0, 1'b0);
    // Switch to ch1, then reset asynchronously while the counter is at 2.
    addRow(1'b0, D1, 3'd1, 1'b1, 1'b1, 3'd3, 4'hB, 1'b0, 1'b0);
    addRow(1'b0, D1, 3'd0, 1'b0, 1'b0, 3'd3, IDLE, 1'b1, 1'b0);
    addRow(1'b1, D1, 3'd0, 1'b0, 1'b1, 3'd0, IDLE, 1'b0, 1'b0);
    addRow(1'b1, D1, 3'd0, 1'b0, 1'b1, 3'd0, IDLE, 1'b0, 1'b0);
    addRow(1'b0, D1, 3'd0, 1'b0, 1'b1, 3'd0, IDLE, 1'b0, 1'b0);
    // Request equal to N_CH is the first out-of-range index.
    addRow(1'b0, D1, 3'd6, 1'b1, 1'b1, 3'd0, 4'h8, 1'b0, 1'b0);
    addRow(1'b0, D1, 3'd0, 1'b0, 1'b1, 3'd0, 4'h8, 1'b0, 1'b1);
    addRow(1'b0, D1, 3'd0, 1'b0, 1'b1, 3'd0, 4'h8, 1'b0, 1'b0);

    for (int i = 0; i < stimTab.size(); i++)
      applyStimulus(i);

    @(posedge clk);
    @(negedge clk);
    #1;
    checkCount++;
    if (scoreQ.size() == 0) begin
      passCount++;
    end else begin
      $display("[TB] FAIL scoreboard drain: got %0d pending, expected 0", scoreQ.size());
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

  // Watchdog so the run cannot stall indefinitely.
  initial begin
    #20000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $display("%0d/%0d checks passed", passCount, checkCount + 1);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
